// File: rtl/uart_byte_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, oversampled mid-bit sampling, strobed byte/error outputs.
// Define UART_RX_PARITY_EN to add an even-parity bit (PARITY state and parity_err strobe).
module uart_byte_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [2:0] dbg_state
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W   = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_BREAK  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               rxd_m_q, rxd_s_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q;
  logic               valid_q, frame_err_q;
  logic               load_good, set_ferr;
  logic               tick, sample_mid, sample_bit;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d;
  logic               parity_err_q, set_perr;
`endif

  assign tick       = (div_q == DIV_LAST);
  assign sample_mid = tick && (smp_q == SMP_MID);
  assign sample_bit = tick && (smp_q == SMP_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    load_good = 1'b0;
    set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    set_perr  = 1'b0;
`endif
    // Tick/sample counters free-run outside IDLE; IDLE pins them to zero so phase follows the start edge.
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + SMP_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        smp_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (sample_mid) begin
          if (rxd_s_q) begin
            state_d = S_IDLE;
          end else begin
            // Restart the bit count here so every later wrap of smp lands mid-bit.
            state_d = S_DATA;
            smp_d   = '0;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (sample_bit) begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample_bit) begin
          par_d   = rxd_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample_bit) begin
          if (rxd_s_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) set_perr = 1'b1;
            else                   load_good = 1'b1;
`else
            load_good = 1'b1;
`endif
          end else begin
            set_ferr = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rxd_m_q      <= 1'b1;
      rxd_s_q      <= 1'b1;
      div_q        <= '0;
      smp_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rxd_m_q      <= rxd;
      rxd_s_q      <= rxd_m_q;
      div_q        <= div_d;
      smp_q        <= smp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      if (load_good) data_q <= shift_q;
      valid_q      <= load_good;
      frame_err_q  <= set_ferr;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= set_perr;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: directed line scenarios plus random frames, scoreboarded against a frame-level model.
module tb_uart_byte_rx;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int OS     = 16;
  localparam int BIT    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Expected event encoding: [9:8] kind (0 byte, 1 frame error, 2 parity error), [7:0] byte.
  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_PERR = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy;
  logic       perr;
  logic [2:0] dbg_state;

  logic [9:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         passes = 0;

  uart_byte_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr),
`endif
    .dbg_state (dbg_state)
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Driver tasks (all line changes on the falling edge)
  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    logic [1:0] kind;
    if (!stop_b)                                kind = K_FERR;
    else if (PAR_EN && ($countones({b, par_b}) % 2 == 1)) kind = K_PERR;
    else                                        kind = K_BYTE;
    exp_q.push_back({kind, b});
    if (kind == K_BYTE) last_good = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [9:0] e;
    logic [1:0] kind;
    int         n;
    if (!rst) begin
      n = int'(valid) + int'(frame_err) + int'(perr);
      if (n > 1) chk("strobes_exclusive", n, 1);
      if (n != 0) begin
        kind = valid ? K_BYTE : (frame_err ? K_FERR : K_PERR);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, kind}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, kind}, {30'd0, e[9:8]});
          if (valid) chk("rx_byte", {24'd0, data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop_b, par_b;
    int         gap;
    logic [7:0] b2b[8] = '{8'h7E, 8'h12, 8'h34, 8'h56, 8'h78, 8'h7D, 8'h5E, 8'h7E};

    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'h0);
    chk("reset_valid", {31'd0, valid}, 32'h0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    idle(50);

    // Single byte; busy must already be low when the stop bit ends
    send_good(8'h7E);
    chk("busy_after_single", {31'd0, busy}, 32'h0);
    idle(100);

    // Back-to-back, zero idle gap
    foreach (b2b[i]) send_good(b2b[i]);
    idle(200);

    // Start-bit glitch
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    idle(200);
    chk("busy_after_glitch", {31'd0, busy}, 32'h0);
    send_good(8'h55);
    idle(100);

    // Framing error followed by a held-low line
    send_frame(8'hA5, 1'b0, ^8'hA5);
    rxd = 1'b0;
    repeat (320) @(negedge clk);
    idle(100);
    chk("data_held_after_ferr", {24'd0, data}, {24'd0, last_good});
    chk("busy_after_break", {31'd0, busy}, 32'h0);
    send_good(8'h3C);
    idle(100);

    // Reset in the middle of data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rxd = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("busy_after_rst", {31'd0, busy}, 32'h0);
    chk("valid_after_rst", {31'd0, valid}, 32'h0);
    repeat (BIT / 2 - 2) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    if (PAR_EN) drive_bit(1'b1);
    drive_bit(1'b1);
    send_good(8'h81);
    idle(100);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(100);
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(100);
    chk("data_held_after_perr", {24'd0, data}, 32'h7E);
`endif

    // Random frames with random gaps and occasional line errors
    for (int i = 0; i < 12; i++) begin
      b      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 5) != 0);
      par_b  = (^b) ^ ($urandom_range(0, 4) == 0);
      gap    = stop_b ? 40 * $urandom_range(0, 3) : 40 + $urandom_range(0, 200);
      send_frame(b, stop_b, par_b);
      if (gap > 0) idle(gap);
    end

    idle(2 * BIT);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_data", {24'd0, data}, {24'd0, last_good});
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
